pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  - Detects load-use hazards and taken branches.
//  - Freezes the pipe while data memory is busy (req/ready handshake).
//  - Traps a memory timeout.
//  - Drives per-register enable/flush. Register rule: flush wins over enable; flush zeroes the bundle at the next clk edge.
// PARAMETERS
//  REG_W        5   register-specifier width
//  MEM_TIMEOUT  15  max consecutive MEM_WAIT cycles before trap; 0 = timeout disabled
//  CNT_W        16  width of the timeout counter and the perf counters
// PORTS
//  clk            in   1      clock, rising edge
//  reset          in   1      asynchronous, active-high
//  id_rs          in   REG_W  rs of instruction in ID
//  id_rt          in   REG_W  rt of instruction in ID
//  id_uses_rt     in   1      ID instruction reads rt as a source
//  ex_mem_read    in   1      instruction in EX is a load
//  ex_rt          in   REG_W  load destination in EX
//  ex_branch_taken in  1      branch resolved taken in EX
//  mem_req        in   1      MEM stage accessing data memory this cycle
//  mem_ready      in   1      data memory completes access this cycle
//  pc_en          out  1      PC update enable
//  if_id_en       out  1      IF/ID enable
//  if_id_flush    out  1      IF/ID flush
//  id_ex_en       out  1      ID/EX enable
//  id_ex_flush    out  1      ID/EX flush
//  ex_mem_en      out  1      EX/MEM enable
//  mem_wb_en      out  1      MEM/WB enable
//  mem_wb_flush   out  1      MEM/WB bubble insert
//  mem_timeout    out  1      sticky trap flag
//  stall_cycles   out  CNT_W  perf counter: cycles with pc_en=0
//  flush_count    out  CNT_W  perf counter: branch flushes
// BEHAVIOUR
//  Reset/outputs
//  - reset (async): state=RUN, wait_cnt=0, mem_timeout=0, counters=0.
//  - While reset is high, all en/flush outputs = 0.
//  - en/flush outputs are combinational from state and inputs (0-cycle latency); all state is registered.
//  FSM states: RUN, MEM_WAIT, TRAP
//  RUN, mem_req & !mem_ready
//  - All en=0, mem_wb_flush=1. Next state MEM_WAIT, wait_cnt=1.
//  RUN, else
//  - Default: all en=1, all flush=0.
//  - Branch: if ex_branch_taken, if_id_flush=1, id_ex_flush=1, pc_en=1; flush_count+1.
//  - Load-use, only if no taken branch:
//    - Condition: ex_mem_read & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
//    - Action: pc_en=0, if_id_en=0, id_ex_flush=1. EX/MEM and MEM/WB advance.
//    - The hazard clears naturally next cycle; exactly 1 bubble.
//  - Taken branch beats load-use: the dependent instruction is squashed anyway.
//  MEM_WAIT
//  - !mem_ready: all en=0, mem_wb_flush=1 so WB never repeats; wait_cnt+1 (saturating).
//  - Timeout: if MEM_TIMEOUT!=0 and wait_cnt==MEM_TIMEOUT with !mem_ready, go to TRAP.
//  - mem_ready=1: evaluate exactly as RUN with no memory stall (branch/load-use apply that cycle). Next state RUN, wait_cnt=0.
//  TRAP
//  - All en=0, all flush=0, mem_timeout=1. Exit only via reset.
//  Boundaries
//  - mem_req & mem_ready in RUN: no stall.
//  - ex_branch_taken held during MEM_WAIT is not counted until the exit cycle.
//  - Reset mid-MEM_WAIT: immediate return to RUN with outputs 0.
//  - Perf counters saturate at all-ones (no wrap). stall_cycles counts every cycle with pc_en=0 outside reset, including TRAP.
// CONFIGURATION
//  PIPE_PERF_CNT_EN
//  - Defined: stall_cycles and flush_count are implemented as above.
//  - Undefined: both ports are tied to 0 with no counter flops; all other behaviour is identical.
// TESTING
//  1. Reset mid-run -> all en/flush=0 during reset; after release, idle inputs -> all en=1, flush=0, mem_timeout=0.
//  2. ex_mem_read=1, ex_rt=5, id_rs=5 -> one cycle pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1. ex_rt=0 -> no stall.
//  3. Load-use + ex_branch_taken in the same cycle -> pc_en=1, if_id_flush=1, id_ex_flush=1; flush_count+1.
//  4. mem_req=1, mem_ready low 3 cycles then high -> 3 cycles all en=0 with mem_wb_flush=1, then en=1; stall_cycles+=3.
//  5. MEM_TIMEOUT=4, mem_ready never high -> TRAP after 4 wait cycles; mem_timeout=1 held until reset.
//  6. Build without PIPE_PERF_CNT_EN, rerun 4 -> stall_cycles=0, flush_count=0; handshake identical.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Central stall/flush sequencer for the IF/ID, ID/EX, EX/MEM and MEM/WB
//   pipeline registers. Detects load-use hazards and taken branches, freezes
//   the pipe while data memory is busy (req/ready handshake) and traps a
//   memory timeout. Register rule downstream: flush wins over enable, and a
//   flush zeroes the bundle at the next clk edge.
//
//   Build option: define PIPE_PERF_CNT_EN to implement the stall_cycles and
//   flush_count performance counters; without it both ports are tied to 0.
//
// Ports
//   clk, reset                : clock (rising edge), async active-high reset
//   id_rs, id_rt, id_uses_rt  : source specifiers of the instruction in ID
//   ex_mem_read, ex_rt        : load in EX and its destination register
//   ex_branch_taken           : branch resolved taken in EX
//   mem_req, mem_ready        : data-memory handshake from the MEM stage
//   pc_en, *_en, *_flush      : per-register enable/flush (combinational)
//   mem_timeout               : sticky trap flag
//   stall_cycles, flush_count : saturating performance counters
module pipe_hazard_ctrl #(
  parameter int REG_W       = 5,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             mem_wb_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TRAP     = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic             load_use;
  logic             run_eval;

  // Register 0 is hard-wired, so a load targeting it never creates a hazard.
  assign load_use = ex_mem_read && (ex_rt != '0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    run_eval      = 1'b0;
    pc_en         = 1'b0;
    if_id_en      = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_en      = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_en     = 1'b0;
    mem_wb_en     = 1'b0;
    mem_wb_flush  = 1'b0;

    case (state_q)
      RUN: begin
        if (mem_req && !mem_ready) begin
          // Whole pipe frozen; bubble into MEM/WB so WB does not retire twice.
          mem_wb_flush = 1'b1;
          state_d      = MEM_WAIT;
          wait_cnt_d   = CNT_ONE;
        end else begin
          run_eval = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          // Completion cycle behaves exactly like an unstalled RUN cycle.
          run_eval   = 1'b1;
          state_d    = RUN;
          wait_cnt_d = '0;
        end else begin
          mem_wb_flush = 1'b1;
          if (wait_cnt_q != CNT_MAX) wait_cnt_d = wait_cnt_q + CNT_ONE;
          if ((MEM_TIMEOUT != 0) && (wait_cnt_q == TIMEOUT_C)) begin
            state_d       = TRAP;
            mem_timeout_d = 1'b1;
          end
        end
      end
      TRAP: begin
        state_d       = TRAP;
        mem_timeout_d = 1'b1;
      end
      default: state_d = RUN;
    endcase

    if (run_eval) begin
      pc_en     = 1'b1;
      if_id_en  = 1'b1;
      id_ex_en  = 1'b1;
      ex_mem_en = 1'b1;
      mem_wb_en = 1'b1;
      // A taken branch squashes the dependent instruction, so it beats load-use.
      if (ex_branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end

    if (reset) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_en     = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      mem_wb_flush = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign mem_timeout = mem_timeout_q;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  // if_id_flush is raised only by a taken branch, so it marks a branch flush.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (!pc_en && (stall_cycles_q != CNT_MAX))
      stall_cycles_d = stall_cycles_q + CNT_ONE;
    if (if_id_flush && (flush_count_q != CNT_MAX))
      flush_count_d = flush_count_q + CNT_ONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int REG_W = 5;
  localparam int CNT_W = 4;
  localparam int TMO   = 4;

`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Output vector order: {pc_en, if_id_en, if_id_flush, id_ex_en,
  //                       id_ex_flush, ex_mem_en, mem_wb_en, mem_wb_flush}
  localparam logic [7:0] O_ZERO  = 8'b0000_0000;
  localparam logic [7:0] O_ALL   = 8'b1101_0110;
  localparam logic [7:0] O_STALL = 8'b0000_0001;
  localparam logic [7:0] O_LU    = 8'b0001_1110;
  localparam logic [7:0] O_BR    = 8'b1111_1110;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [REG_W-1:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic             id_uses_rt = 1'b0, ex_mem_read = 1'b0, ex_branch_taken = 1'b0;
  logic             mem_req = 1'b0, mem_ready = 1'b0;
  logic             pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic             ex_mem_en, mem_wb_en, mem_wb_flush, mem_timeout;
  logic [CNT_W-1:0] stall_cycles, flush_count;
  logic [7:0]       out_vec;

  assign out_vec = {pc_en, if_id_en, if_id_flush, id_ex_en,
                    id_ex_flush, ex_mem_en, mem_wb_en, mem_wb_flush};

  pipe_hazard_ctrl #(.REG_W(REG_W), .MEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .mem_wb_flush(mem_wb_flush),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic             rst;
    logic [REG_W-1:0] rs, rt, ert;
    logic             uses_rt, mrd, br, mreq, mrdy;
    logic [7:0]       exp_o;
    logic             exp_to;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] o;
    logic       to;
    logic [CNT_W-1:0] st, fl;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [CNT_W-1:0] m_stall = '0, m_flush = '0;

  function automatic vec_t v(string name, logic rst, logic [REG_W-1:0] rs,
                             logic [REG_W-1:0] rt, logic uses_rt, logic mrd,
                             logic [REG_W-1:0] ert, logic br, logic mreq,
                             logic mrdy, logic [7:0] exp_o, logic exp_to);
    vec_t r;
    r.name = name; r.rst = rst; r.rs = rs; r.rt = rt; r.uses_rt = uses_rt;
    r.mrd = mrd; r.ert = ert; r.br = br; r.mreq = mreq; r.mrdy = mrdy;
    r.exp_o = exp_o; r.exp_to = exp_to;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(vec_t x);
    reset = x.rst; id_rs = x.rs; id_rt = x.rt; id_uses_rt = x.uses_rt;
    ex_mem_read = x.mrd; ex_rt = x.ert; ex_branch_taken = x.br;
    mem_req = x.mreq; mem_ready = x.mrdy;
  endtask

  function automatic logic [CNT_W-1:0] sat_inc(logic [CNT_W-1:0] c, logic inc);
    if (inc && (c != '1)) return c + CNT_W'(1);
    return c;
  endfunction

  task automatic sb_check();
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb_q.pop_front();
    chk({e.name, ".outs"}, 32'(out_vec), 32'(e.o));
    chk({e.name, ".mem_timeout"}, 32'(mem_timeout), 32'(e.to));
    chk({e.name, ".stall_cycles"}, 32'(stall_cycles), 32'(e.st));
    chk({e.name, ".flush_count"}, 32'(flush_count), 32'(e.fl));
  endtask

  initial begin
    exp_t e;
    // Stimulus table: inputs then expected combinational outputs / trap flag.
    //            name              rst rs rt  ur mrd ert br mreq mrdy  outs    to
    vecs.push_back(v("reset",        1, 0, 0, 0, 0, 0, 0, 0, 0, O_ZERO,  0));
    vecs.push_back(v("idle",         0, 0, 0, 0, 0, 0, 0, 0, 0, O_ALL,   0));
    vecs.push_back(v("lu_rs",        0, 5, 0, 0, 1, 5, 0, 0, 0, O_LU,    0));
    vecs.push_back(v("lu_clear",     0, 5, 0, 0, 0, 5, 0, 0, 0, O_ALL,   0));
    vecs.push_back(v("lu_r0",        0, 0, 0, 0, 1, 0, 0, 0, 0, O_ALL,   0));
    vecs.push_back(v("lu_rt",        0, 1, 7, 1, 1, 7, 0, 0, 0, O_LU,    0));
    vecs.push_back(v("lu_rt_unused", 0, 1, 7, 0, 1, 7, 0, 0, 0, O_ALL,   0));
    vecs.push_back(v("br_beats_lu",  0, 5, 0, 0, 1, 5, 1, 0, 0, O_BR,    0));
    vecs.push_back(v("branch",       0, 0, 0, 0, 0, 0, 1, 0, 0, O_BR,    0));
    vecs.push_back(v("mem_hit",      0, 0, 0, 0, 0, 0, 0, 1, 1, O_ALL,   0));
    vecs.push_back(v("mem_miss",     0, 0, 0, 0, 0, 0, 0, 1, 0, O_STALL, 0));
    vecs.push_back(v("mem_wait1",    0, 0, 0, 0, 0, 0, 0, 1, 0, O_STALL, 0));
    vecs.push_back(v("mem_wait_br",  0, 0, 0, 0, 0, 0, 1, 1, 0, O_STALL, 0));
    vecs.push_back(v("mem_exit_br",  0, 0, 0, 0, 0, 0, 1, 1, 1, O_BR,    0));
    vecs.push_back(v("miss2",        0, 0, 0, 0, 0, 0, 0, 1, 0, O_STALL, 0));
    vecs.push_back(v("mem_exit_lu",  0, 9, 0, 0, 1, 9, 0, 1, 1, O_LU,    0));
    vecs.push_back(v("miss3",        0, 0, 0, 0, 0, 0, 0, 1, 0, O_STALL, 0));
    vecs.push_back(v("reset_in_wait",1, 0, 0, 0, 0, 0, 0, 1, 0, O_ZERO,  0));
    vecs.push_back(v("run_after_rst",0, 0, 0, 0, 0, 0, 0, 0, 0, O_ALL,   0));
    for (int i = 0; i < TMO + 1; i++)
      vecs.push_back(v("to_wait",    0, 0, 0, 0, 0, 0, 0, 1, 0, O_STALL, 0));
    for (int i = 0; i < 16; i++)
      vecs.push_back(v("trap",       0, 3, 3, 1, i[0], 3, i[1], i[2], 1'b1, O_ZERO, 1));
    vecs.push_back(v("trap_reset",   1, 0, 0, 0, 0, 0, 0, 0, 0, O_ZERO,  0));
    vecs.push_back(v("post_trap",    0, 0, 0, 0, 0, 0, 0, 0, 0, O_ALL,   0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      apply(vecs[i]);
      e.name = vecs[i].name;
      e.o    = vecs[i].exp_o;
      e.to   = vecs[i].exp_to;
      e.st   = (PERF && !vecs[i].rst) ? m_stall : '0;
      e.fl   = (PERF && !vecs[i].rst) ? m_flush : '0;
      sb_q.push_back(e);
      if (vecs[i].rst) begin
        m_stall = '0;
        m_flush = '0;
      end else begin
        m_stall = sat_inc(m_stall, !vecs[i].exp_o[7]);
        m_flush = sat_inc(m_flush, vecs[i].exp_o[5]);
      end
      @(negedge clk);
      sb_check();
    end
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    // Zero-latency response: outputs follow inputs inside one cycle.
    @(posedge clk); #1;
    apply(v("comb", 0, 4, 0, 0, 1, 4, 0, 0, 0, O_LU, 0));
    #1 chk("comb_lu", 32'(out_vec), 32'(O_LU));
    ex_branch_taken = 1'b1;
    #1 chk("comb_br", 32'(out_vec), 32'(O_BR));
    apply(v("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, O_ALL, 0));

    // Asynchronous reset asserted mid-cycle while in MEM_WAIT.
    @(posedge clk); #1;
    mem_req = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    chk("async_miss", 32'(out_vec), 32'(O_STALL));
    @(posedge clk); #3;
    chk("async_wait", 32'(out_vec), 32'(O_STALL));
    reset = 1'b1;
    #1;
    chk("async_rst_outs", 32'(out_vec), 32'(O_ZERO));
    chk("async_rst_stall", 32'(stall_cycles), 32'd0);
    chk("async_rst_flush", 32'(flush_count), 32'd0);
    @(negedge clk); #1;
    reset = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    #1;
    // mem_ready low would keep a MEM_WAIT state stalled; RUN enables everything.
    chk("async_back_to_run", 32'(out_vec), 32'(O_ALL));
    chk("async_timeout_clr", 32'(mem_timeout), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
